aes_byte_loader: RTL and testbench

//   Upstream stage of the AES-128 encrypt/decrypt pair. Collects a byte-serial

---
 rtl/aes_byte_loader.sv | 90 +++++++++
 tb/tb_aes_byte_loader.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/aes_byte_loader.sv
`default_nettype none
// ============================================================================
// Module      : aes_byte_loader
// Description : Packs a byte-serial stream into 128-bit blocks and hands them
//               to the AES core over valid/ready, with one block of buffering.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_byte_loader #(
  parameter int BLOCK_BYTES = 16,
  parameter int CNT_W       = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [7:0]                 in_data,
  output logic                       blk_valid,
  input  logic                       blk_ready,
  output logic [8*BLOCK_BYTES-1:0]   blk_data,
  output logic [7:0]                 blk_count
);

  localparam int               BLOCK_W = 8 * BLOCK_BYTES;
  localparam logic [CNT_W-1:0] c_full  = CNT_W'(BLOCK_BYTES);
  localparam logic [CNT_W-1:0] c_last  = CNT_W'(BLOCK_BYTES - 1);

  logic [CNT_W-1:0]   r_cnt;
  logic [BLOCK_W-1:0] r_shreg;
  logic [BLOCK_W-1:0] r_blk_data;
  logic               r_blk_valid;
  logic [7:0]         r_blk_count;

  logic               w_accept;
  logic               w_slot_free;
  logic               w_pend;
  logic               w_load_fill;
  logic               w_load_pend;
  logic [BLOCK_W-1:0] w_shreg_next;

  // State is implied by the fill count: c_full means a finished block is
  // parked in the shift register waiting for the output slot.
  assign in_ready     = !rst && (r_cnt < c_full);
  assign w_accept     = in_valid && in_ready && !clear;
  assign w_slot_free  = !r_blk_valid || blk_ready;
  assign w_pend       = (r_cnt == c_full);
  assign w_shreg_next = {r_shreg[BLOCK_W-9:0], in_data};
  assign w_load_fill  = w_accept && (r_cnt == c_last) && w_slot_free;
  assign w_load_pend  = w_pend && w_slot_free && !clear;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_shreg     <= '0;
      r_blk_data  <= '0;
      r_blk_valid <= 1'b0;
      r_blk_count <= 8'd0;
    end else begin
      if (w_accept) begin
        r_shreg <= w_shreg_next;
      end

      if (clear || w_load_pend) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        if (r_cnt == c_last) begin
          r_cnt <= w_slot_free ? '0 : c_full;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end

      // A new block takes priority over retiring the old one, so a
      // consume-and-complete edge keeps blk_valid high.
      if (w_load_fill || w_load_pend) begin
        r_blk_data  <= w_load_fill ? w_shreg_next : r_shreg;
        r_blk_valid <= 1'b1;
        r_blk_count <= r_blk_count + 8'd1;
      end else if (blk_ready) begin
        r_blk_valid <= 1'b0;
      end
    end
  end

  assign blk_valid = r_blk_valid;
  assign blk_data  = r_blk_data;
  assign blk_count = r_blk_count;

endmodule
`default_nettype wire

// File: tb/tb_aes_byte_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_byte_loader
// Description : Directed self-checking bench for aes_byte_loader.
// Revision    : 1.1 - checks routed through a checking task
// ============================================================================
module tb_aes_byte_loader;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         r_clear = 1'b0;
    logic         r_in_valid = 1'b0;
    logic         w_in_ready;
    logic [7:0]   r_in_data = 8'd0;
    logic         w_blk_valid;
    logic         r_blk_ready = 1'b0;
    logic [127:0] w_blk_data;
    logic [7:0]   w_blk_count;

    int r_checks = 0;
    int r_errors = 0;

    aes_byte_loader #(.BLOCK_BYTES(16), .CNT_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (r_clear),
        .in_valid  (r_in_valid),
        .in_ready  (w_in_ready),
        .in_data   (r_in_data),
        .blk_valid (w_blk_valid),
        .blk_ready (r_blk_ready),
        .blk_data  (w_blk_data),
        .blk_count (w_blk_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        r_checks++;
        if (obs !== exp) begin
            r_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] mk(input logic [7:0] base, input logic [7:0] step);
        logic [127:0] d = '0;
        logic [7:0]   b = base;
        for (int i = 0; i < 16; i++) begin
            d = {d[119:0], b};
            b = b + step;
        end
        return d;
    endfunction

    // Drives n consecutive bytes, one per cycle, then idles in_valid.
    task automatic send(input int n, input logic [7:0] base, input logic [7:0] step);
        logic [7:0] b = base;
        for (int i = 0; i < n; i++) begin
            r_in_valid = 1'b1;
            r_in_data  = b;
            tick();
            b = b + step;
        end
        r_in_valid = 1'b0;
    endtask

    logic [127:0] r_exp_blk;
    logic [127:0] r_blk_a;
    logic [127:0] r_last_blk;
    int           r_got;

    initial begin
        // Reset state
        #2 rst = 1'b1;
        #1;
        check("rst_in_ready", w_in_ready, 1'b0);
        check("rst_blk_valid", w_blk_valid, 1'b0);
        check("rst_blk_data", w_blk_data, 128'd0);
        check("rst_blk_count", w_blk_count, 8'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("rel_in_ready", w_in_ready, 1'b1);

        // 1: 00,11,..,ff with blk_ready held high
        r_blk_ready = 1'b1;
        send(15, 8'h00, 8'h11);
        check("t1_not_yet_valid", w_blk_valid, 1'b0);
        send(1, 8'hff, 8'h00);
        check("t1_valid", w_blk_valid, 1'b1);
        check("t1_data", w_blk_data, 128'h00112233445566778899aabbccddeeff);
        check("t1_count", w_blk_count, 8'd1);
        tick();
        check("t1_consumed", w_blk_valid, 1'b0);
        check("t1_data_kept", w_blk_data, 128'h00112233445566778899aabbccddeeff);

        // 2: back-to-back blocks with the consumer stalled
        r_blk_ready = 1'b0;
        r_blk_a = mk(8'h10, 8'h01);
        send(16, 8'h10, 8'h01);
        check("t2_a_valid", w_blk_valid, 1'b1);
        check("t2_a_data", w_blk_data, r_blk_a);
        check("t2_a_count", w_blk_count, 8'd2);
        send(16, 8'h80, 8'h01);
        check("t2_pend_in_ready", w_in_ready, 1'b0);
        check("t2_a_held", w_blk_data, r_blk_a);
        check("t2_a_held_valid", w_blk_valid, 1'b1);
        check("t2_count_held", w_blk_count, 8'd2);
        tick();
        check("t2_still_held", w_blk_data, r_blk_a);
        check("t2_still_blocked", w_in_ready, 1'b0);
        r_blk_ready = 1'b1;
        tick();
        r_blk_ready = 1'b0;
        check("t2_b_data", w_blk_data, mk(8'h80, 8'h01));
        check("t2_b_valid", w_blk_valid, 1'b1);
        check("t2_b_count", w_blk_count, 8'd3);
        check("t2_in_ready_back", w_in_ready, 1'b1);
        r_blk_ready = 1'b1;
        tick();
        check("t2_b_consumed", w_blk_valid, 1'b0);

        // 3: partial block aborted by clear, byte offered during clear ignored
        send(7, 8'he0, 8'h01);
        r_clear    = 1'b1;
        r_in_valid = 1'b1;
        r_in_data  = 8'h55;
        tick();
        r_clear    = 1'b0;
        r_in_valid = 1'b0;
        check("t3_clear_no_block", w_blk_valid, 1'b0);
        send(16, 8'h30, 8'h03);
        check("t3_data", w_blk_data, mk(8'h30, 8'h03));
        check("t3_count", w_blk_count, 8'd4);

        // 4: asynchronous reset between edges after byte 9
        r_blk_ready = 1'b0;
        send(9, 8'hc0, 8'h01);
        check("t4_pre_valid", w_blk_valid, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("t4_async_valid", w_blk_valid, 1'b0);
        check("t4_async_in_ready", w_in_ready, 1'b0);
        check("t4_async_data", w_blk_data, 128'd0);
        check("t4_async_count", w_blk_count, 8'd0);
        tick();
        rst = 1'b0;
        r_blk_ready = 1'b1;
        send(16, 8'h01, 8'h07);
        check("t4_clean_data", w_blk_data, mk(8'h01, 8'h07));
        check("t4_clean_count", w_blk_count, 8'd1);

        // 5: 256 blocks with random in_valid gaps; count wraps to 0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int b = 0; b < 256; b++) begin
            r_exp_blk = '0;
            r_got = 0;
            while (r_got < 16) begin
                r_in_valid = ($urandom_range(0, 1) == 1);
                r_in_data  = 8'($urandom);
                if (r_in_valid) begin
                    r_exp_blk = {r_exp_blk[119:0], r_in_data};
                    r_got++;
                end
                tick();
            end
            r_in_valid = 1'b0;
            check("t5_valid", w_blk_valid, 1'b1);
            check("t5_data", w_blk_data, r_exp_blk);
        end
        check("t5_count_wrap", w_blk_count, 8'd0);
        r_last_blk = r_exp_blk;

        // 6: block parked in PEND, then clear together with blk_ready
        r_blk_ready = 1'b0;
        send(16, 8'h40, 8'h01);
        check("t6_pend_in_ready", w_in_ready, 1'b0);
        check("t6_held_data", w_blk_data, r_last_blk);
        r_blk_ready = 1'b1;
        r_clear     = 1'b1;
        tick();
        r_clear     = 1'b0;
        r_blk_ready = 1'b0;
        check("t6_valid_fell", w_blk_valid, 1'b0);
        check("t6_count_same", w_blk_count, 8'd0);
        check("t6_data_kept", w_blk_data, r_last_blk);
        check("t6_in_ready", w_in_ready, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", r_checks, r_errors);
        $finish;
    end

endmodule
`default_nettype wire
